// File: rtl/uart_port_ctrl.sv
// UART pin handshake engine: strobes rdn/wrn on the shared Ram1 low byte, buffers RX bytes
// in a small FIFO and tracks TX completion (tbre/tsre) with a per-wait timeout.
module uart_port_ctrl #(
  parameter int unsigned RD_LOW_CYC = 2,
  parameter int unsigned WR_LOW_CYC = 2,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               data_ready_i,
  input  logic               tbre_i,
  input  logic               tsre_i,
  output logic               rdn_o,
  output logic               wrn_o,
  inout  wire  [7:0]         bus_data_io,
  output logic               bus_req_o,
  input  logic               bus_gnt_i,
  output logic [7:0]         rx_data_o,
  output logic               rx_valid_o,
  input  logic               rx_pop_i,
  output logic [FIFO_AW:0]   rx_count_o,
  input  logic [7:0]         tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic               tx_err_o,
  input  logic               err_clr_i,
  output logic [3:0]         state_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StRxReq   = 4'd1;
  localparam logic [3:0] StRxLow   = 4'd2;
  localparam logic [3:0] StRxRel   = 4'd3;
  localparam logic [3:0] StTxReq   = 4'd4;
  localparam logic [3:0] StTxSetup = 4'd5;
  localparam logic [3:0] StTxLow   = 4'd6;
  localparam logic [3:0] StTxHold  = 4'd7;
  localparam logic [3:0] StTxTbre  = 4'd8;
  localparam logic [3:0] StTxTsre  = 4'd9;

  logic [3:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         tx_q, tx_d;
  logic               rdn_q, wrn_q, req_q, drv_q, err_q, err_d;
  logic               push, pop, timeout, full;
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;

  // Occupancy never exceeds Depth, so the MSB alone marks full.
  assign full       = count_q[FIFO_AW];
  assign pop        = rx_pop_i && rx_valid_o;
  assign rx_valid_o = (count_q != '0);
  assign rx_data_o  = mem_q[rptr_q];
  assign rx_count_o = count_q;
  assign tx_ready_o = (state_q == StIdle) && !(data_ready_i && !full);

  assign rdn_o       = rdn_q;
  assign wrn_o       = wrn_q;
  assign bus_req_o   = req_q;
  assign tx_err_o    = err_q;
  assign state_o     = state_q;
  assign bus_data_io = drv_q ? tx_q : 8'hzz;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    push    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      StIdle: begin
        if (data_ready_i && !full) begin
          state_d = StRxReq;
        end else if (tx_valid_i) begin
          tx_d    = tx_data_i;
          state_d = StTxReq;
        end
      end
      StRxReq: if (bus_gnt_i) begin
        state_d = StRxLow;
        cnt_d   = '0;
      end
      StRxLow: begin
        if (cnt_q == 16'(RD_LOW_CYC - 1)) begin
          push    = 1'b1;
          state_d = StRxRel;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRxRel: state_d = StIdle;
      StTxReq: if (bus_gnt_i) state_d = StTxSetup;
      StTxSetup: begin
        state_d = StTxLow;
        cnt_d   = '0;
      end
      StTxLow: begin
        if (cnt_q == 16'(WR_LOW_CYC - 1)) state_d = StTxHold;
        else cnt_d = cnt_q + 16'd1;
      end
      StTxHold: begin
        state_d = StTxTbre;
        cnt_d   = '0;
      end
      StTxTbre, StTxTsre: begin
        if ((state_q == StTxTbre) ? tbre_i : tsre_i) begin
          state_d = (state_q == StTxTbre) ? StTxTsre : StIdle;
          cnt_d   = '0;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A timeout in the same cycle as err_clr keeps the flag set.
    err_d = timeout ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      req_q   <= 1'b0;
      drv_q   <= 1'b0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rdn_q   <= (state_d != StRxLow);
      wrn_q   <= (state_d != StTxLow);
      req_q   <= (state_d inside {StRxReq, StRxLow, StRxRel, StTxReq, StTxSetup, StTxLow,
                                  StTxHold});
      drv_q   <= (state_d inside {StTxSetup, StTxLow, StTxHold});
      err_q   <= err_d;
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      if (push && !pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= bus_data_io;
  end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Directed bench for uart_port_ctrl: table of TX transactions plus hand-written RX, FIFO,
// arbitration, grant-stall and reset sequences.
module tb_uart_port_ctrl;

  localparam int unsigned ToCyc = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       data_ready, tbre, tsre, rdn, wrn, bus_req, bus_gnt;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_pop, tx_valid, tx_ready, tx_err, err_clr;
  logic [2:0] rx_count;
  logic [3:0] state;
  wire  [7:0] bus_data;
  logic       tb_drv;
  logic [7:0] tb_val;

  assign bus_data = tb_drv ? tb_val : 8'hzz;

  always #5 CLK = ~CLK;

  uart_port_ctrl #(
    .RD_LOW_CYC(2),
    .WR_LOW_CYC(2),
    .TIMEOUT   (ToCyc),
    .FIFO_AW   (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .data_ready_i(data_ready),
    .tbre_i      (tbre),
    .tsre_i      (tsre),
    .rdn_o       (rdn),
    .wrn_o       (wrn),
    .bus_data_io (bus_data),
    .bus_req_o   (bus_req),
    .bus_gnt_i   (bus_gnt),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_pop_i    (rx_pop),
    .rx_count_o  (rx_count),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .tx_err_o    (tx_err),
    .err_clr_i   (err_clr),
    .state_o     (state)
  );

  typedef struct {
    logic [7:0] data;
    int         tbre_dly;   // cycles spent in TX_TBRE before tbre rises
    int         tsre_dly;   // cycles spent in TX_TSRE before tsre rises
    logic       clr_same;   // pulse err_clr in the final timeout cycle
    int         exp_err;
  } tx_vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic run_rx(input logic [7:0] b, input bit pop_on_push);
    int rl = 0;
    int k  = 0;
    tb_val     = b;
    tb_drv     = 1'b1;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("rx_enter_req", int'(state), 1);
    while (state != 4'd0 && k < 20) begin
      tick();
      k++;
      if (!rdn) rl++;
      // On the last RX_LOW cycle, pop so the push edge also pops.
      rx_pop = pop_on_push && (state == 4'd2) && (rl == 2);
    end
    rx_pop = 1'b0;
    tb_drv = 1'b0;
    chk("rx_rdn_low_cycles", rl, 2);
  endtask

  task automatic run_tx(input tx_vec_t v);
    int wl = 0;
    int k  = 0;
    tbre     = 1'b0;
    tsre     = 1'b0;
    bus_gnt  = 1'b1;
    tx_data  = v.data;
    tx_valid = 1'b1;
    #1;
    chk("tx_ready_idle", int'(tx_ready), 1);
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    chk("tx_enter_req", int'(state), 4);
    while (state != 4'd8 && k < 20) begin
      tick();
      k++;
      if (!wrn) wl++;
      if (state inside {4'd5, 4'd6, 4'd7}) chk("tx_bus_data", int'(bus_data), int'(v.data));
    end
    chk("tx_wrn_low_cycles", wl, 2);
    chk("tx_tbre_bus_req", int'(bus_req), 0);
    k = 0;
    while (state == 4'd8 && k < 20) begin
      tbre    = (k >= v.tbre_dly);
      err_clr = v.clr_same && (k == ToCyc - 1);
      tick();
      k++;
    end
    k = 0;
    while (state == 4'd9 && k < 20) begin
      tsre    = (k >= v.tsre_dly);
      err_clr = v.clr_same && (k == ToCyc - 1);
      tick();
      k++;
    end
    err_clr = 1'b0;
    tbre    = 1'b0;
    tsre    = 1'b0;
    chk("tx_end_idle", int'(state), 0);
    chk("tx_err", int'(tx_err), v.exp_err);
    if (tx_err) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("tx_err_clr", int'(tx_err), 0);
    end
  endtask

  tx_vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k, lows, badreq;
    logic [7:0] exp_b [4];
    vecs[0] = '{8'hA5, 3, 5, 1'b0, 0};
    vecs[1] = '{8'h3C, 0, 0, 1'b0, 0};
    vecs[2] = '{8'hFF, 7, 7, 1'b0, 0};  // last cycle before timeout
    vecs[3] = '{8'h00, 8, 0, 1'b0, 1};  // tbre one cycle too late
    vecs[4] = '{8'h81, 2, 8, 1'b0, 1};  // tsre timeout
    vecs[5] = '{8'h5A, 20, 0, 1'b1, 1}; // set beats clear
    vecs[6] = '{8'hC3, 1, 20, 1'b0, 1};

    RST = 1'b0; data_ready = 0; tbre = 0; tsre = 0; bus_gnt = 1; rx_pop = 0;
    tx_data = 0; tx_valid = 0; err_clr = 0; tb_drv = 0; tb_val = 0;
    #12;
    chk("rst_rdn", int'(rdn), 1);
    chk("rst_wrn", int'(wrn), 1);
    chk("rst_bus_req", int'(bus_req), 0);
    chk("rst_rx_count", int'(rx_count), 0);
    chk("rst_tx_err", int'(tx_err), 0);
    chk("rst_state", int'(state), 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Single RX, then pop, then pop on empty
    run_rx(8'h5A, 1'b0);
    chk("rx1_valid", int'(rx_valid), 1);
    chk("rx1_data", int'(rx_data), 'h5A);
    chk("rx1_count", int'(rx_count), 1);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    chk("rx1_pop_count", int'(rx_count), 0);
    chk("rx1_pop_valid", int'(rx_valid), 0);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    chk("pop_empty_count", int'(rx_count), 0);

    // Fill FIFO, data_ready held: no strobe while full
    for (int i = 1; i <= 4; i++) run_rx(8'(i), 1'b0);
    chk("full_count", int'(rx_count), 4);
    tb_val = 8'h05; tb_drv = 1'b1; data_ready = 1'b1;
    #1;
    chk("full_tx_ready", int'(tx_ready), 1);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!rdn || state != 4'd0) lows++;
    end
    chk("full_no_strobe", lows, 0);
    chk("full_head", int'(rx_data), 1);
    data_ready = 1'b0;
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    chk("full_pop_count", int'(rx_count), 3);
    run_rx(8'h05, 1'b0);
    chk("wrap_count", int'(rx_count), 4);
    exp_b = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order", int'(rx_data), int'(exp_b[i]));
      rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    end
    chk("wrap_empty", int'(rx_valid), 0);

    // Push and pop in the same cycle
    run_rx(8'h11, 1'b0);
    run_rx(8'h22, 1'b1);
    chk("pushpop_count", int'(rx_count), 1);
    chk("pushpop_head", int'(rx_data), 'h22);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;

    // TX vector table
    for (int i = 0; i < 7; i++) run_tx(vecs[i]);

    // RX beats TX when both request in the same cycle
    tb_val = 8'h77; tb_drv = 1'b1; data_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
    #1;
    chk("arb_tx_ready", int'(tx_ready), 0);
    tick();
    data_ready = 1'b0;
    chk("arb_rx_first", int'(state), 1);
    k = 0;
    while (state != 4'd0 && k < 20) begin tick(); k++; end
    tb_drv = 1'b0;
    #1;
    chk("arb_tx_ready_after", int'(tx_ready), 1);
    tick();
    tx_valid = 1'b0;
    chk("arb_tx_second", int'(state), 4);
    chk("arb_rx_byte", int'(rx_data), 'h77);
    tbre = 1'b1; tsre = 1'b1;
    k = 0;
    while (state != 4'd0 && k < 20) begin tick(); k++; end
    tbre = 1'b0; tsre = 1'b0;
    chk("arb_tx_done", int'(state), 0);
    chk("arb_tx_err", int'(tx_err), 0);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;

    // Grant withheld for 10 cycles: request held, no strobes
    bus_gnt = 1'b0; tb_val = 8'h66; tb_drv = 1'b1; data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    lows = 0; badreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rdn) lows++;
      if (!bus_req) badreq++;
    end
    chk("nognt_rx_rdn", lows, 0);
    chk("nognt_rx_req", badreq, 0);
    bus_gnt = 1'b1;
    k = 0;
    while (state != 4'd0 && k < 20) begin tick(); k++; if (!rdn) lows++; end
    tb_drv = 1'b0;
    chk("gnt_rx_rdn", lows, 2);
    chk("gnt_rx_data", int'(rx_data), 'h66);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;

    bus_gnt = 1'b0; tx_data = 8'h3A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    lows = 0; badreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!wrn) lows++;
      if (!bus_req || state != 4'd4) badreq++;
    end
    chk("nognt_tx_wrn", lows, 0);
    chk("nognt_tx_req", badreq, 0);
    bus_gnt = 1'b1; tbre = 1'b1; tsre = 1'b1;
    k = 0;
    while (state != 4'd0 && k < 20) begin tick(); k++; if (!wrn) lows++; end
    tbre = 1'b0; tsre = 1'b0;
    chk("gnt_tx_wrn", lows, 2);

    // Reset mid-TX_LOW with a pending error and a buffered byte
    run_rx(8'h42, 1'b0);
    tx_valid = 1'b1; tx_data = 8'h10;
    tick();
    tx_valid = 1'b0;
    k = 0;
    while (state != 4'd0 && k < 40) begin tick(); k++; end
    chk("pre_rst_err", int'(tx_err), 1);
    tx_valid = 1'b1; tx_data = 8'h20;
    tick();
    tx_valid = 1'b0;
    k = 0;
    while (state != 4'd6 && k < 20) begin tick(); k++; end
    chk("pre_rst_txlow", int'(state), 6);
    RST = 1'b0;
    #1;
    chk("mid_rst_rdn", int'(rdn), 1);
    chk("mid_rst_wrn", int'(wrn), 1);
    chk("mid_rst_bus_req", int'(bus_req), 0);
    chk("mid_rst_rx_count", int'(rx_count), 0);
    chk("mid_rst_tx_err", int'(tx_err), 0);
    chk("mid_rst_state", int'(state), 0);
    tick();
    @(negedge CLK);
    RST = 1'b1;
    tick();
    #1;
    chk("post_rst_tx_ready", int'(tx_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
